time_keeper: RTL

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD clock with a prescaled seconds tick, manual set and 12/24-hour display.
// Build with TIME_KEEPER_ALARM_EN defined to include the HH:MM alarm and the Alarm_Out latch.
module time_keeper #(
  parameter int unsigned TICK_DIV       = 100000000,
  parameter int unsigned HOLD_RESET_SEC = 1
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       Inc_Min,
  input  logic       Inc_Hour,
  input  logic       Hold,
  input  logic       Mode_12h,
  input  logic       Alarm_Sel,
  input  logic       Alarm_Ack,
  output logic [3:0] Hours_Tens,
  output logic [3:0] Hours_Units,
  output logic [3:0] Min_Tens,
  output logic [3:0] Min_Units,
  output logic [5:0] Seconds,
  output logic       Pm,
  output logic       Sec_Pulse,
  output logic       Alarm_Out
);

  localparam int unsigned  PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]   SEC_LAST   = 6'd59;

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] hu;
    logic [2:0] mt;
    logic [3:0] mu;
  } hhmm_t;

  // Minutes 00..59 in BCD, no carry into the hour.
  function automatic hhmm_t inc_min(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.mu == 4'd9) begin
      r.mu = 4'd0;
      r.mt = (t.mt == 3'd5) ? 3'd0 : t.mt + 3'd1;
    end else begin
      r.mu = t.mu + 4'd1;
    end
    return r;
  endfunction

  // Hours 00..23 in BCD, wrapping to 00.
  function automatic hhmm_t inc_hour(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.ht == 2'd2 && t.hu == 4'd3) begin
      r.ht = 2'd0;
      r.hu = 4'd0;
    end else if (t.hu == 4'd9) begin
      r.ht = t.ht + 2'd1;
      r.hu = 4'd0;
    end else begin
      r.hu = t.hu + 4'd1;
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic          hold_q, hold_d;
  logic [5:0]    sec_q, sec_d;
  hhmm_t         time_q, time_d;

  logic [3:0]    hours_tens_q, hours_tens_d;
  logic [3:0]    hours_units_q, hours_units_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [3:0]    min_units_q, min_units_d;
  logic [5:0]    seconds_out_q, seconds_out_d;
  logic          pm_q, pm_d;
  logic          sec_pulse_q, sec_pulse_d;

  logic          hold_rise_c;
  logic          tick_c;
  logic [5:0]    tick_sec_c;
  hhmm_t         ticked_c;
  hhmm_t         disp_src_c;
  logic          inc_min_time_c;
  logic          inc_hour_time_c;

  // Prescaler, tick carry chain, then manual increments on the post-tick value.
  always_comb begin
    hold_rise_c = Hold & ~hold_q & (HOLD_RESET_SEC != 32'd0);
    tick_c      = ~Hold & (presc_q == PRESC_LAST);

    presc_d = presc_q;
    if (hold_rise_c || tick_c) begin
      presc_d = '0;
    end else if (!Hold) begin
      presc_d = presc_q + PW'(1);
    end

    tick_sec_c = sec_q;
    ticked_c   = time_q;
    if (tick_c) begin
      if (sec_q == SEC_LAST) begin
        tick_sec_c = '0;
        ticked_c   = inc_min(time_q);
        if (time_q.mt == 3'd5 && time_q.mu == 4'd9) begin
          ticked_c = inc_hour(ticked_c);
        end
      end else begin
        tick_sec_c = sec_q + 6'd1;
      end
    end

    sec_d  = tick_sec_c;
    time_d = ticked_c;
    if (inc_min_time_c) begin
      time_d = inc_min(time_d);
    end
    if (inc_hour_time_c) begin
      time_d = inc_hour(time_d);
    end

    hold_d      = Hold;
    sec_pulse_d = tick_c;

    if (Reset) begin
      presc_d     = '0;
      hold_d      = 1'b0;
      sec_d       = '0;
      time_d      = '0;
      sec_pulse_d = 1'b0;
    end
  end

  // Display registers follow the stored time one cycle later; reset shows midnight.
  always_comb begin
    disp_src_c = time_q;
    if (Reset) begin
      disp_src_c = '0;
    end

    hours_tens_d  = {2'b00, disp_src_c.ht};
    hours_units_d = disp_src_c.hu;
    min_tens_d    = {1'b0, disp_src_c.mt};
    min_units_d   = disp_src_c.mu;
    seconds_out_d = Reset ? 6'd0 : sec_q;
    pm_d          = (disp_src_c.ht == 2'd2) ||
                    (disp_src_c.ht == 2'd1 && disp_src_c.hu >= 4'd2);

    if (Mode_12h) begin
      if (disp_src_c.ht == 2'd0 && disp_src_c.hu == 4'd0) begin
        hours_tens_d  = 4'd1;
        hours_units_d = 4'd2;
      end else if (disp_src_c.ht == 2'd1 && disp_src_c.hu >= 4'd3) begin
        hours_tens_d  = 4'd0;
        hours_units_d = disp_src_c.hu - 4'd2;
      end else if (disp_src_c.ht == 2'd2) begin
        // 20..23 map to 08..11
        if (disp_src_c.hu <= 4'd1) begin
          hours_tens_d  = 4'd0;
          hours_units_d = disp_src_c.hu + 4'd8;
        end else begin
          hours_tens_d  = 4'd1;
          hours_units_d = disp_src_c.hu - 4'd2;
        end
      end
    end
  end

  always_ff @(posedge Clk_100M) begin
    presc_q       <= presc_d;
    hold_q        <= hold_d;
    sec_q         <= sec_d;
    time_q        <= time_d;
    hours_tens_q  <= hours_tens_d;
    hours_units_q <= hours_units_d;
    min_tens_q    <= min_tens_d;
    min_units_q   <= min_units_d;
    seconds_out_q <= seconds_out_d;
    pm_q          <= pm_d;
    sec_pulse_q   <= sec_pulse_d;
  end

  assign Hours_Tens  = hours_tens_q;
  assign Hours_Units = hours_units_q;
  assign Min_Tens    = min_tens_q;
  assign Min_Units   = min_units_q;
  assign Seconds     = seconds_out_q;
  assign Pm          = pm_q;
  assign Sec_Pulse   = sec_pulse_q;

`ifdef TIME_KEEPER_ALARM_EN
  hhmm_t      alarm_q, alarm_d;
  logic [5:0] alarm_cnt_q, alarm_cnt_d;
  logic       alarm_out_q, alarm_out_d;
  logic       alarm_hit_c;

  assign inc_min_time_c  = Inc_Min  & ~Alarm_Sel;
  assign inc_hour_time_c = Inc_Hour & ~Alarm_Sel;

  // Alarm fires on the tick landing on HH:MM:00; Ack beats a same-cycle set; 60 ticks time out.
  always_comb begin
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    alarm_out_d = alarm_out_q;
    alarm_hit_c = tick_c && (tick_sec_c == 6'd0) && (ticked_c == alarm_q);

    if (Alarm_Sel && Inc_Min) begin
      alarm_d = inc_min(alarm_d);
    end
    if (Alarm_Sel && Inc_Hour) begin
      alarm_d = inc_hour(alarm_d);
    end

    if (Alarm_Ack) begin
      alarm_out_d = 1'b0;
    end else if (alarm_hit_c) begin
      alarm_out_d = 1'b1;
      alarm_cnt_d = '0;
    end else if (alarm_out_q && tick_c) begin
      if (alarm_cnt_q == SEC_LAST) begin
        alarm_out_d = 1'b0;
      end else begin
        alarm_cnt_d = alarm_cnt_q + 6'd1;
      end
    end

    if (Reset) begin
      alarm_d     = '0;
      alarm_cnt_d = '0;
      alarm_out_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_100M) begin
    alarm_q     <= alarm_d;
    alarm_cnt_q <= alarm_cnt_d;
    alarm_out_q <= alarm_out_d;
  end

  assign Alarm_Out = alarm_out_q;
`else
  logic unused_alarm_c;

  assign inc_min_time_c  = Inc_Min;
  assign inc_hour_time_c = Inc_Hour;
  assign unused_alarm_c  = Alarm_Sel ^ Alarm_Ack;
  assign Alarm_Out       = 1'b0;
`endif

endmodule
